// File: rtl/trap_control_if.sv
// trap_control_if: bundle between the writeback stage / CSR file and trap_control.
//   Instruction side : valid_in, pc_in, csr_op/address/old/operand/src_zero,
//                      exception flags, is_mret.
//   CSR file inputs  : eip, tip, sip, trap_vector, mret_vector.
//   CSR file outputs : write_enable/address/data, retired, traped, mret, ecp,
//                      trap_cause, interupt, rd_write_allow.
//   Fetch outputs    : redirect, redirect_target, flush.
// master = writeback/CSR side driving the instruction; slave = trap_control.
interface trap_control_if;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [1:0]  csr_op;
  logic [11:0] csr_address;
  logic [31:0] csr_old;
  logic [31:0] csr_operand;
  logic        csr_src_zero;
  logic        exc_fetch_misaligned;
  logic        exc_illegal;
  logic        exc_ebreak;
  logic        exc_load_misaligned;
  logic        exc_store_misaligned;
  logic        exc_ecall;
  logic        is_mret;
  logic        eip;
  logic        tip;
  logic        sip;
  logic [31:0] trap_vector;
  logic [31:0] mret_vector;

  logic        write_enable;
  logic [11:0] write_address;
  logic [31:0] write_data;
  logic        retired;
  logic        traped;
  logic        mret;
  logic [31:0] ecp;
  logic [3:0]  trap_cause;
  logic        interupt;
  logic        rd_write_allow;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        flush;

  modport master (
    output valid_in, pc_in, csr_op, csr_address, csr_old, csr_operand, csr_src_zero,
           exc_fetch_misaligned, exc_illegal, exc_ebreak, exc_load_misaligned,
           exc_store_misaligned, exc_ecall, is_mret, eip, tip, sip, trap_vector, mret_vector,
    input  write_enable, write_address, write_data, retired, traped, mret, ecp, trap_cause,
           interupt, rd_write_allow, redirect, redirect_target, flush
  );

  modport slave (
    input  valid_in, pc_in, csr_op, csr_address, csr_old, csr_operand, csr_src_zero,
           exc_fetch_misaligned, exc_illegal, exc_ebreak, exc_load_misaligned,
           exc_store_misaligned, exc_ecall, is_mret, eip, tip, sip, trap_vector, mret_vector,
    output write_enable, write_address, write_data, retired, traped, mret, ecp, trap_cause,
           interupt, rd_write_allow, redirect, redirect_target, flush
  );
endinterface

// File: rtl/trap_control.sv
// trap_control: writeback-side controller for the machine-mode CSR file.
// For each accepted instruction it selects one outcome: interrupt, exception,
// mret, or normal retire (with optional CSR read-modify-write). Traps and mret
// produce a registered fetch redirect followed by a fixed-length flush window
// during which incoming instructions are ignored.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - trap_control_if.slave (instruction, CSR file and fetch signals)
// Parameters:
//   FLUSH_CYCLES - cycles flush stays high after the redirect cycle (>= 1)
module trap_control #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  trap_control_if.slave bus
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            redirect_q, redirect_d;
  logic [31:0]     redirect_target_q, redirect_target_d;

  // Decode of the accepted instruction
  logic        accept;
  logic        irq_pending;
  logic        exc_pending;
  logic        take_trap;
  logic        take_mret;
  logic [3:0]  irq_cause;
  logic [3:0]  exc_cause;
  logic        csr_write;
  logic [31:0] csr_wdata;

  always_comb begin
    accept      = bus.valid_in && (state_q == StRun);
    irq_pending = bus.eip || bus.sip || bus.tip;
    exc_pending = bus.exc_fetch_misaligned || bus.exc_illegal || bus.exc_ebreak ||
                  bus.exc_ecall || bus.exc_load_misaligned || bus.exc_store_misaligned;
    take_trap   = accept && (irq_pending || exc_pending);
    take_mret   = accept && !irq_pending && !exc_pending && bus.is_mret;

    // Interrupt priority: external > software > timer
    if (bus.eip)      irq_cause = 4'd11;
    else if (bus.sip) irq_cause = 4'd3;
    else              irq_cause = 4'd7;

    if (bus.exc_fetch_misaligned)      exc_cause = 4'd0;
    else if (bus.exc_illegal)          exc_cause = 4'd2;
    else if (bus.exc_ebreak)           exc_cause = 4'd3;
    else if (bus.exc_ecall)            exc_cause = 4'd11;
    else if (bus.exc_load_misaligned)  exc_cause = 4'd4;
    else                               exc_cause = 4'd6;

    // RS/RC with a zero source never write, so they cannot fault on read-only CSRs
    csr_write = accept && !irq_pending && !exc_pending && !bus.is_mret &&
                (bus.csr_op != 2'b00) && ((bus.csr_op == 2'b01) || !bus.csr_src_zero);

    unique case (bus.csr_op)
      2'b01:   csr_wdata = bus.csr_operand;
      2'b10:   csr_wdata = bus.csr_old | bus.csr_operand;
      2'b11:   csr_wdata = bus.csr_old & ~bus.csr_operand;
      default: csr_wdata = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StRun;
      cnt_q             <= '0;
      redirect_q        <= 1'b0;
      redirect_target_q <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      redirect_q        <= redirect_d;
      redirect_target_q <= redirect_target_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    redirect_d        = 1'b0;
    redirect_target_d = redirect_target_q;
    unique case (state_q)
      StRun: begin
        if (take_trap || take_mret) begin
          state_d           = StFlush;
          cnt_d             = CntW'(FLUSH_CYCLES);
          redirect_d        = 1'b1;
          redirect_target_d = take_trap ? bus.trap_vector : bus.mret_vector;
        end
      end
      StFlush: begin
        // The redirect cycle plus FLUSH_CYCLES further cycles are spent here
        if (cnt_q == '0) state_d = StRun;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs
  always_comb begin
    bus.write_enable    = csr_write;
    bus.write_address   = csr_write ? bus.csr_address : 12'h000;
    bus.write_data      = csr_write ? csr_wdata : 32'h0;
    bus.retired         = accept && !irq_pending && !exc_pending;
    bus.traped          = take_trap;
    bus.mret            = take_mret;
    bus.ecp             = take_trap ? bus.pc_in : 32'h0;
    bus.interupt        = take_trap && irq_pending;
    bus.trap_cause      = !take_trap ? 4'd0 : (irq_pending ? irq_cause : exc_cause);
    bus.rd_write_allow  = accept && !irq_pending && !exc_pending && !bus.is_mret;
    bus.redirect        = redirect_q;
    bus.redirect_target = redirect_target_q;
    bus.flush           = (state_q == StFlush);
  end

endmodule

// File: doc/trap_control.md
Name: trap_control

Overview:
- Writeback-side controller that drives the machine-mode CSR file's write, retire and trap interface. It consumes the pending-interrupt lines (eip/tip/sip) and the trap_vector/mret_vector outputs from that file.
- Decides, per instruction reaching writeback, between three outcomes:
  - retire, with an optional CSR read-modify-write;
  - take an exception or interrupt;
  - execute mret.
- On a trap or mret it issues a registered redirect to fetch. It then holds a pipeline flush for a fixed drain window.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays high after the redirect cycle (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_in  in  1  instruction present in writeback
pc_in  in  32  its PC
csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
csr_address  in  12  target CSR
csr_old  in  32  CSR value read at decode
csr_operand  in  32  rs1 or zimm value
csr_src_zero  in  1  rs1/zimm field is zero (suppresses RS/RC write)
exc_fetch_misaligned  in  1  cause 0
exc_illegal  in  1  cause 2
exc_ebreak  in  1  cause 3
exc_load_misaligned  in  1  cause 4
exc_store_misaligned  in  1  cause 6
exc_ecall  in  1  cause 11
is_mret  in  1  instruction is mret
eip, tip, sip  in  1 each  gated pending interrupts from the CSR file
trap_vector  in  32  from the CSR file
mret_vector  in  32  from the CSR file
write_enable  out  1  CSR write strobe
write_address  out  12  CSR write address
write_data  out  32  CSR write data
retired  out  1  instruction retired
traped  out  1  trap taken
mret  out  1  mret executed
ecp  out  32  trap PC
trap_cause  out  4  cause code
interupt  out  1  cause is an interrupt
rd_write_allow  out  1  rd writeback permitted
redirect  out  1  fetch redirect strobe
redirect_target  out  32  fetch target
flush  out  1  squash fetch/decode/execute/memory

Behaviour:
- Acceptance: an instruction is accepted when valid_in=1 and state=RUN. Instructions arriving in FLUSH are ignored: no outputs, no retire.
- CSR-side outputs (write_enable, write_address, write_data, retired, traped, mret, ecp, trap_cause, interupt, rd_write_allow) are combinational from the accepted instruction. The CSR file samples them at the same edge.
- Outcome priority for an accepted instruction:
  1. Interrupt: eip (cause 11) > sip (3) > tip (7). Sets traped=1, interupt=1, ecp=pc_in. The instruction is not retired.
  2. Exception, in order fetch_misaligned > illegal > ebreak > ecall > load_misaligned > store_misaligned. Sets traped=1, interupt=0, ecp=pc_in.
  3. is_mret: mret=1, retired=1.
  4. Otherwise: retired=1, rd_write_allow=1.
- CSR writes happen only in case 4, with csr_op!=0.
  - Write condition: op=RW, or csr_src_zero=0.
  - write_data: RW = operand; RS = old|operand; RC = old&~operand.
  - write_address = csr_address.
- Trap or mret: trap_vector or mret_vector is captured the same cycle into redirect_target.
  - Next cycle: redirect=1 for exactly one cycle, flush=1.
  - State enters FLUSH. flush stays high for FLUSH_CYCLES further cycles, then state returns to RUN.
- All other outputs are 0 when nothing is accepted.
- Reset: state=RUN; redirect=0, flush=0, redirect_target=0; drain counter=0. A reset mid-flush aborts the drain; the next cycle is RUN with flush=0.
- Simultaneous events:
  - An interrupt pending on an mret or CSR instruction wins; no CSR write, mret=0.
  - A trap on the cycle the drain counter expires cannot occur, because instructions are ignored in FLUSH.

Test Plan:
- Plain ALU instruction accepted at pc=0x100, no pending events -> retired=1, rd_write_allow=1, no redirect.
- csr_op=RS, csr_address=0x300, old=0x8, operand=0x80, src_zero=0 -> write_enable=1, write_data=0x88. Repeat with src_zero=1 -> write_enable=0, retired=1.
- exc_illegal and exc_ecall together at pc=0x200, trap_vector=0x1000 -> traped=1, trap_cause=2, ecp=0x200, retired=0. Next cycle redirect=1, target=0x1000. flush high for 3 cycles total; valid_in during drain ignored.
- eip=1 and tip=1 with a CSR RW instruction at pc=0x300 -> trap_cause=11, interupt=1, write_enable=0, retired=0.
- is_mret at pc=0x400, mret_vector=0x204 -> mret=1, retired=1. Next cycle redirect=1, target=0x204.
- reset asserted in the second flush cycle -> flush=0 and redirect=0 the following cycle; next valid instruction retires normally.
